// File: rtl/instr_mem_loader.sv
// instr_mem_loader: assembles MSB-first bytes into words, writes them to
// instruction memory and owns the memory address port while loading.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_start begins a load;
//   i_byte/i_byte_valid/o_byte_ready byte stream handshake; i_fetch_pc fetch PC;
//   o_mem_addr/o_mem_data/o_mem_we memory port; o_cpu_stall, o_busy, o_done,
//   o_error status; o_words_loaded count of words written in this load.
module instr_mem_loader #(
    parameter int unsigned NBITS     = 32,
    parameter int unsigned CELDAS    = 60,
    parameter int unsigned MAX_WORDS = CELDAS / 4,
    parameter logic [NBITS-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [7:0]       i_byte,
    input  logic             i_byte_valid,
    output logic             o_byte_ready,
    input  logic [NBITS-1:0] i_fetch_pc,
    output logic [NBITS-1:0] o_mem_addr,
    output logic [NBITS-1:0] o_mem_data,
    output logic             o_mem_we,
    output logic             o_cpu_stall,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic [7:0]       o_words_loaded
);

    localparam int unsigned IDX_W = $clog2(MAX_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_WORDS - 1);
    localparam logic [7:0] MAX_W8 = 8'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [NBITS-1:0] word_q, word_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic [7:0]       words_loaded_q, words_loaded_d;

    logic             accept;
    logic [NBITS-1:0] load_addr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= S_IDLE;
            byte_cnt_q     <= '0;
            word_q         <= '0;
            word_idx_q     <= '0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            word_q         <= word_d;
            word_idx_q     <= word_idx_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    always_comb begin
        load_addr = '0;
        load_addr[IDX_W+1:2] = word_idx_q;
    end

    assign accept = i_byte_valid && o_byte_ready;

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        word_d         = word_q;
        word_idx_d     = word_idx_q;
        words_loaded_d = words_loaded_q;
        o_byte_ready   = 1'b0;
        o_mem_we       = 1'b0;

        unique case (state_q)
            S_IDLE, S_ERROR: begin
                // A new load starts from a clean slate in either state.
                if (i_start) begin
                    state_d        = S_RECV;
                    byte_cnt_d     = '0;
                    word_d         = '0;
                    word_idx_d     = '0;
                    words_loaded_d = '0;
                end
            end
            S_RECV: begin
                o_byte_ready = 1'b1;
                if (accept) begin
                    word_d     = {word_q[NBITS-9:0], i_byte};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                o_mem_we = 1'b1;
                if (words_loaded_q < MAX_W8) begin
                    words_loaded_d = words_loaded_q + 8'd1;
                end
                // The halt marker is itself written before finishing.
                if (word_q == HALT_WORD) begin
                    state_d = S_DONE;
                end else if (word_idx_q == LAST_IDX) begin
                    state_d = S_ERROR;
                end else begin
                    word_idx_d = word_idx_q + 1'b1;
                    state_d    = S_RECV;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Loader owns the address port in every state except IDLE.
    assign o_mem_addr     = (state_q == S_IDLE) ? i_fetch_pc : load_addr;
    assign o_mem_data     = word_q;
    assign o_cpu_stall    = (state_q != S_IDLE);
    assign o_busy         = (state_q == S_RECV) || (state_q == S_WRITE);
    assign o_done         = (state_q == S_DONE);
    assign o_error        = (state_q == S_ERROR);
    assign o_words_loaded = words_loaded_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed bench for instr_mem_loader.
// Drives on falling edges, checks on falling edges against fixed values.
module tb_instr_mem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] fetch_pc;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;
    logic        cpu_stall;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  words_loaded;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [0:15];
    int we_cnt = 0;
    int acc_cnt = 0;
    int done_cnt = 0;

    instr_mem_loader dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_byte         (byte_in),
        .i_byte_valid   (byte_valid),
        .o_byte_ready   (byte_ready),
        .i_fetch_pc     (fetch_pc),
        .o_mem_addr     (mem_addr),
        .o_mem_data     (mem_data),
        .o_mem_we       (mem_we),
        .o_cpu_stall    (cpu_stall),
        .o_busy         (busy),
        .o_done         (done),
        .o_error        (err),
        .o_words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory and event counters observed at the active edge.
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[5:2]] <= mem_data;
            we_cnt <= we_cnt + 1;
        end
        if (byte_valid && byte_ready) acc_cnt <= acc_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Present a byte from a falling edge until it is taken; gap adds idle cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        byte_in = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'(byte_ready), 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
        for (int g = 0; g < gap; g++) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    int we0;
    int acc0;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        rst_n = 1'b0;
        start = 1'b0;
        byte_in = 8'h00;
        byte_valid = 1'b0;
        fetch_pc = 32'h0000_0040;
        @(negedge clk);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_cnt", 32'(words_loaded), 32'd0);
        chk("rst_addr", mem_addr, 32'h40);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: basic two-word program ending on the halt marker.
        pulse_start();
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_ready", 32'(byte_ready), 32'd1);
        send_word(32'h0001_1027, 0);
        send_word(32'hFFFF_FFFF, 0);
        chk("t1_we", 32'(mem_we), 32'd1);
        chk("t1_waddr", mem_addr, 32'h4);
        chk("t1_wdata", mem_data, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_dstall", 32'(cpu_stall), 32'd1);
        chk("t1_cnt", 32'(words_loaded), 32'd2);
        @(negedge clk);
        chk("t1_stall_off", 32'(cpu_stall), 32'd0);
        chk("t1_done_off", 32'(done), 32'd0);
        chk("t1_pulses", 32'(done_cnt), 32'd1);
        chk("t1_mem0", mem[0], 32'h0001_1027);
        chk("t1_mem1", mem[1], 32'hFFFF_FFFF);
        chk("t1_we_total", 32'(we_cnt), 32'd2);

        // 2: same program with valid toggling every cycle.
        mem[0] = 32'h0;
        mem[1] = 32'h0;
        we0 = we_cnt;
        acc0 = acc_cnt;
        pulse_start();
        send_word(32'h0001_1027, 1);
        send_word(32'hFFFF_FFFF, 1);
        @(negedge clk);
        @(negedge clk);
        chk("t2_mem0", mem[0], 32'h0001_1027);
        chk("t2_mem1", mem[1], 32'hFFFF_FFFF);
        chk("t2_acc", 32'(acc_cnt - acc0), 32'd8);
        chk("t2_we", 32'(we_cnt - we0), 32'd2);
        chk("t2_cnt", 32'(words_loaded), 32'd2);

        // 3: capacity overflow without a halt marker.
        we0 = we_cnt;
        pulse_start();
        for (int i = 0; i < 15; i++) send_word(32'h1000_0000 | 32'(i), 0);
        chk("t3_last_addr", mem_addr, 32'd56);
        @(negedge clk);
        chk("t3_error", 32'(err), 32'd1);
        chk("t3_stall", 32'(cpu_stall), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_cnt", 32'(words_loaded), 32'd15);
        chk("t3_we", 32'(we_cnt - we0), 32'd15);
        chk("t3_mem0", mem[0], 32'h1000_0000);
        chk("t3_mem14", mem[14], 32'h1000_000E);
        acc0 = acc_cnt;
        byte_in = 8'h5A;
        byte_valid = 1'b1;
        @(negedge clk);
        chk("t3_ready", 32'(byte_ready), 32'd0);
        @(negedge clk);
        byte_valid = 1'b0;
        chk("t3_noacc", 32'(acc_cnt - acc0), 32'd0);
        chk("t3_hold", 32'(err), 32'd1);
        chk("t3_hold_stall", 32'(cpu_stall), 32'd1);
        pulse_start();
        chk("t3_err_clr", 32'(err), 32'd0);
        chk("t3_busy2", 32'(busy), 32'd1);
        chk("t3_cnt_clr", 32'(words_loaded), 32'd0);
        chk("t3_addr0", mem_addr, 32'h0);

        // 4: reset after two bytes of the second word.
        send_word(32'h1234_5678, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        we0 = we_cnt;
        fetch_pc = 32'h0000_0020;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_we", 32'(mem_we), 32'd0);
        chk("t4_stall", 32'(cpu_stall), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_addr", mem_addr, 32'h20);
        chk("t4_cnt", 32'(words_loaded), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t4_mem0", mem[0], 32'h1234_5678);
        chk("t4_nowr", 32'(we_cnt - we0), 32'd0);

        // 5: fetch owns the port in IDLE, loader owns it otherwise.
        fetch_pc = 32'h0000_0014;
        byte_in = 8'h77;
        byte_valid = 1'b1;
        we0 = we_cnt;
        acc0 = acc_cnt;
        @(negedge clk);
        chk("t5_addr", mem_addr, 32'h14);
        chk("t5_ready", 32'(byte_ready), 32'd0);
        @(negedge clk);
        byte_valid = 1'b0;
        chk("t5_nowr", 32'(we_cnt - we0), 32'd0);
        chk("t5_noacc", 32'(acc_cnt - acc0), 32'd0);
        pulse_start();
        chk("t5_recv_addr0", mem_addr, 32'h0);
        send_word(32'hDEAD_BEEF, 0);
        @(negedge clk);
        chk("t5_recv_addr1", mem_addr, 32'h4);
        chk("t5_recv_busy", 32'(busy), 32'd1);
        send_word(32'hFFFF_FFFF, 0);
        @(negedge clk);
        @(negedge clk);
        chk("t5_idle_addr", mem_addr, 32'h14);
        chk("t5_mem0", mem[0], 32'hDEAD_BEEF);
        chk("t5_mem1", mem[1], 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
